// File: rtl/multibyte_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_adder
// Purpose  : Combinational 8-bit ripple-carry adder. This is the single adder
//            that multibyte_add_sequencer reuses across every byte of an
//            operand.
// Ports    : A, B  - 8-bit addends
//            Cin   - carry into bit 0
//            Sum   - 8-bit sum
//            Carry - carry out of bit 7
// Revision : 1.0 - initial release
// ============================================================================
module eight_bit_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Carry
);

  // c[i] is the carry into bit i.
  logic [8:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
  end

  assign Carry = c[8];

endmodule

// ============================================================================
// Module   : multibyte_add_sequencer
// Purpose  : Adds two NBYTES-wide operands by running one eight_bit_adder over
//            the bytes, least significant byte first, one byte per clock. The
//            carry between bytes is held in a register. The result is
//            published only once the whole operation has finished.
// Params   : NBYTES - bytes per operand (1..16); operand width W = 8*NBYTES
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous active-high reset
//            start  - request, accepted on a rising edge while ready=1
//            a, b   - W-bit operands, sampled at acceptance
//            cin    - carry into byte 0, sampled at acceptance
//            ready  - high only while idle
//            busy   - high while adding or signalling done
//            done   - one-cycle completion pulse
//            sum    - W-bit result of the last completed operation
//            cout   - carry out of the last completed operation
// Revision : 1.0 - initial release
// ============================================================================
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int W    = 8 * NBYTES;
  // Byte index width: one bit minimum so that NBYTES=1 still has a real index.
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      next_state;

  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    work_reg;
  logic            carry_reg;
  logic [IDXW-1:0] idx;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      add_sum;
  logic            add_carry;
  logic [W-1:0]    work_next;
  logic            is_last;

  assign is_last = (idx == LAST_IDX);

  // --------------------------------------------------------------------------
  // Datapath: select the current byte of each operand, run the shared adder,
  // and splice its result into the working value.
  // --------------------------------------------------------------------------
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) begin
        a_byte = a_reg[8*k +: 8];
        b_byte = b_reg[8*k +: 8];
      end
    end
  end

  eight_bit_adder u_adder (a_byte, b_byte, carry_reg, add_sum, add_carry);

  // work_next is the working value including the byte being added this cycle,
  // so the final byte is already present when the result is published.
  always_comb begin
    work_next = work_reg;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) begin
        work_next[8*k +: 8] = add_sum;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        if (is_last) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (Moore, decoded from state only)
  // --------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_ADD: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture, per-byte accumulation and result publication.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            work_reg  <= '0;
          end
        end
        ST_ADD: begin
          work_reg  <= work_next;
          carry_reg <= add_carry;
          if (is_last) begin
            // Publish only the complete result; sum/cout stay frozen at all
            // other times so that partial results are never visible.
            sum  <= work_next;
            cout <= add_carry;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          // DONE: nothing to update; the state machine returns to IDLE.
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multibyte_add_sequencer
// Purpose  : Self-checking bench for multibyte_add_sequencer. It uses one
//            NBYTES=4 instance and one NBYTES=1 instance. Expected results come
//            from plain integer addition, and expected timing is counted in
//            clock edges from acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multibyte_add_sequencer;

  logic        clk;
  logic        reset;

  logic        start4;
  logic [31:0] a4;
  logic [31:0] b4;
  logic        cin4;
  logic        ready4;
  logic        busy4;
  logic        done4;
  logic [31:0] sum4;
  logic        cout4;

  logic        start1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        cin1;
  logic        ready1;
  logic        busy1;
  logic        done1;
  logic [7:0]  sum1;
  logic        cout1;

  int checks;
  int errors;

  multibyte_add_sequencer #(.NBYTES(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .ready (ready4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  multibyte_add_sequencer #(.NBYTES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .ready (ready1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the result is {cout, sum} of a plain (W+1)-bit addition.
  function automatic logic [32:0] ref_add4(input logic [31:0] x, input logic [31:0] y, input logic c);
    return 33'(x) + 33'(y) + 33'(c);
  endfunction

  function automatic logic [8:0] ref_add1(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // One operation on the 4-byte instance. Acceptance is edge E0, and done must
  // be seen only after edge E4. Operands are scrambled after acceptance.
  task automatic do_op4(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input string name);
    logic [32:0] exp;
    exp = ref_add4(ta, tb, tc);
    @(negedge clk);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom);
    checks++;
    if (ready4 !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: ready=%b busy=%b, want ready=0 busy=1", name, ready4, busy4);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (done4 !== (k == 4)) begin
        errors++;
        $display("FAIL %s done timing at edge %0d: done=%b want %b", name, k, done4, (k == 4));
      end
    end
    checks++;
    if ({cout4, sum4} !== exp) begin
      errors++;
      $display("FAIL %s result: cout=%b sum=%h, want cout=%b sum=%h", name, cout4, sum4, exp[32], exp[31:0]);
    end
    @(negedge clk);
    checks++;
    if (ready4 !== 1'b1 || done4 !== 1'b0 || {cout4, sum4} !== exp) begin
      errors++;
      $display("FAIL %s after done: ready=%b done=%b sum=%h, want ready=1 done=0 sum=%h",
               name, ready4, done4, sum4, exp[31:0]);
    end
  endtask

  // One operation on the 1-byte instance; done must follow acceptance by one edge.
  task automatic do_op1(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input string name);
    logic [8:0] exp;
    exp = ref_add1(ta, tb, tc);
    @(negedge clk);
    a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom);
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy1, done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
      errors++;
      $display("FAIL %s: done=%b cout=%b sum=%0d, want done=1 cout=%b sum=%0d",
               name, done1, cout1, sum1, exp[8], exp[7:0]);
    end
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL %s return: ready=%b done=%b, want ready=1 done=0", name, ready1, done1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 32'h0 || cout4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: ready=%b busy=%b done=%b sum=%h cout=%b", ready4, busy4, done4, sum4, cout4);
    end
    checks++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 8'h0 || cout1 !== 1'b0) begin
      errors++;
      $display("FAIL reset1: ready=%b busy=%b done=%b sum=%h cout=%b", ready1, busy1, done1, sum1, cout1);
    end
    // reset wins over start when both are active on an edge
    start4 = 1'b1;
    @(negedge clk);
    checks++;
    if (ready4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_start: ready=%b busy=%b, want ready=1 busy=0", ready4, busy4);
    end
    start4 = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_directed;
    do_op4(32'h000000FF, 32'h00000001, 1'b0, "byte_carry");
    do_op4(32'hFFFFFFFF, 32'h00000000, 1'b1, "full_ripple");
  endtask

  task automatic test_busy_ignore;
    logic [32:0] exp;
    int          n_done;
    exp    = ref_add4(32'h12345678, 32'h11111111, 1'b0);
    n_done = 0;
    @(negedge clk);
    a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a4 = 32'hFFFFFFFF; b4 = 32'hFFFFFFFF; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        n_done++;
        checks++;
        if ({cout4, sum4} !== exp) begin
          errors++;
          $display("FAIL busy_ignore result: cout=%b sum=%h, want cout=%b sum=%h", cout4, sum4, exp[32], exp[31:0]);
        end
      end
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL busy_ignore done count: %0d, want 1", n_done);
    end
    checks++;
    if ({cout4, sum4} !== exp || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore final: sum=%h ready=%b, want sum=%h ready=1", sum4, ready4, exp[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    @(negedge clk);
    a4 = 32'h01010101; b4 = 32'h01010101; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);      // E0 accept
    #1 start4 = 1'b0;
    repeat (2) @(posedge clk);   // E1, E2 ADD edges
    #2 reset = 1'b1;
    #1;
    checks++;
    if (sum4 !== 32'h0 || cout4 !== 1'b0 || done4 !== 1'b0 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: sum=%h cout=%b done=%b ready=%b, want 0 0 0 1", sum4, cout4, done4, ready4);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid abort: done pulses=%0d ready=%b, want 0 and 1", n_done, ready4);
    end
    do_op4(32'd100, 32'd100, 1'b1, "after_reset");
  endtask

  // start held high: accepts every 6 cycles, operands alternate, sum holds
  // between done pulses. Completed operations are tracked in a queue.
  task automatic test_back_to_back;
    logic [32:0] exp_q[$];
    logic [32:0] got;
    logic [32:0] held;
    logic        seen;
    logic        prev_ready;
    logic        sel;
    int          accepts;
    int          last_accept;
    int          n_done;
    seen = 1'b0; sel = 1'b0; accepts = 0; last_accept = 0; n_done = 0; held = '0;
    @(negedge clk);
    a4 = 32'h80000000; b4 = 32'h80000000; cin4 = 1'b0; start4 = 1'b1;
    prev_ready = ready4;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (prev_ready && !ready4) begin
        exp_q.push_back(ref_add4(a4, b4, cin4));
        if (accepts > 0) begin
          checks++;
          if (cyc - last_accept != 6) begin
            errors++;
            $display("FAIL b2b spacing: %0d cycles, want 6", cyc - last_accept);
          end
        end
        last_accept = cyc;
        accepts++;
        sel = ~sel;
        if (sel) begin
          a4 = 32'd5; b4 = 32'd6; cin4 = 1'b1;
        end else begin
          a4 = 32'h80000000; b4 = 32'h80000000; cin4 = 1'b0;
        end
        if (accepts == 4) start4 = 1'b0;
      end
      if (done4 === 1'b1) begin
        n_done++;
        got = {cout4, sum4};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected done: sum=%h", sum4);
        end else begin
          held = exp_q.pop_front();
          if (got !== held) begin
            errors++;
            $display("FAIL b2b result: cout=%b sum=%h, want cout=%b sum=%h", cout4, sum4, held[32], held[31:0]);
          end
        end
        seen = 1'b1;
      end else if (seen) begin
        checks++;
        if ({cout4, sum4} !== held) begin
          errors++;
          $display("FAIL b2b hold: sum=%h, want %h", sum4, held[31:0]);
        end
      end
      prev_ready = ready4;
    end
    checks++;
    if (accepts != 4 || n_done != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b totals: accepts=%0d dones=%0d pending=%0d, want 4 4 0", accepts, n_done, exp_q.size());
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      do_op4($urandom, $urandom, 1'($urandom), "random4");
    end
  endtask

  task automatic test_nbytes1;
    do_op1(8'd200, 8'd200, 1'b0, "nb1_200");
    do_op1(8'd255, 8'd255, 1'b0, "nb1_255");
    for (int i = 0; i < 8; i++) begin
      do_op1(8'($urandom), 8'($urandom), 1'($urandom), "random1");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_nbytes1();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
Sequences the existing combinational eight_bit_adder over NBYTES-wide operands, one byte per clock, LSB byte first. The carry is registered between bytes. The block lets wide additions reuse a single 8-bit adder instance instead of a wide ripple chain. It sits between a requesting unit (start/ready handshake) and one eight_bit_adder instantiated inside it.

Parameters:
NBYTES, 4, number of 8-bit bytes per operand; legal range 1..16; operand width W = 8*NBYTES.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
start  input  1  request; accepted only on a rising edge where ready=1
a  input  W  operand A, sampled at acceptance
b  input  W  operand B, sampled at acceptance
cin  input  1  carry-in to byte 0, sampled at acceptance
ready  output  1  high only in IDLE
busy  output  1  high in ADD and DONE
done  output  1  one-cycle pulse, high only in DONE
sum  output  W  result of last completed operation
cout  output  1  carry-out of last completed operation

Behaviour:
- Reset values (async, immediate): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0. Byte index, carry register, operand registers and work register all 0.
- Datapath: one eight_bit_adder instance, connected positionally as (A, B, Cin, Sum, Carry).
  - A = byte idx of a_reg; B = byte idx of b_reg; Cin = carry_reg.
  - Byte k occupies bits [8k+7:8k].
- State machine IDLE / ADD / DONE:
  - IDLE: on an edge with start=1, latch a→a_reg, b→b_reg, cin→carry_reg; set idx=0; go to ADD. With start=0, remain in IDLE.
  - ADD, each edge: write adder Sum into work byte idx; carry_reg ← adder Carry; idx ← idx+1.
    - On the edge where idx == NBYTES-1, go to DONE instead of incrementing.
    - On that same edge, load sum ← the complete work value (including the final byte) and cout ← the final Carry.
  - DONE: done=1 for exactly one cycle. Next edge always returns to IDLE.
- Latency and throughput:
  - Accept at edge E0; DONE is entered at edge E(NBYTES); done is high from E(NBYTES) to E(NBYTES+1).
  - Minimum acceptance interval is NBYTES+2 cycles.
- sum and cout change only on the edge entering DONE. They hold their value through the following IDLE and ADD phases; partial results are never visible.
- start while busy (ADD or DONE) is ignored, with no queuing. Operand input changes after acceptance have no effect.
- If start is held high continuously, a new operation is accepted on the first IDLE edge, i.e. one cycle after done.
- Arithmetic: the result is modulo 2^W; cout is the carry out of the MSB byte. Carry propagates across all bytes, e.g. all-ones + cin=1 ripples through every byte.
- NBYTES=1: a single ADD cycle; the result equals a direct eight_bit_adder evaluation.
- Reset mid-operation: the operation is aborted and no done is produced. Outputs return to their reset values (sum=0, cout=0). After reset deasserts, the first edge with start=1 is accepted.
- reset and start in the same cycle: reset wins.
- idx width is ceil(log2(NBYTES)), minimum 1 bit; idx never exceeds NBYTES-1.

Test Plan:
1. NBYTES=4, a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0. done pulses exactly 4 edges after acceptance, for 1 cycle; ready low from acceptance until the edge after done.
2. a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, confirming full carry ripple through all 4 bytes.
3. a=0x12345678, b=0x11111111, cin=0 → sum=0x23456789. Pulse start with a=b=0xFFFFFFFF while busy → that start is ignored, the result is unchanged, and only one done is produced.
4. Start a=0x01010101, b=0x01010101; assert reset after 2 ADD edges → sum=0, cout=0, done=0, ready=1 immediately. After release, a=100, b=100, cin=1 → sum=201, cout=0.
5. start held high, with operands alternating (0x80000000+0x80000000, cin=0) and (5+6, cin=1) → results 0 with cout=1, then 12 with cout=0. Accepts are spaced 6 cycles apart, and sum holds between done pulses.
6. NBYTES=1 instance: a=200, b=200, cin=0 → sum=144, cout=1. a=255, b=255, cin=0 → sum=254, cout=1. done 1 edge after acceptance.
